// File: rtl/mem_access_unit_pkg.sv
// Shared types for the CPU memory access unit: FSM state and request-source encodings.
// Also holds the latency counter width helper.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_e;

   // The counter only has to hold MEM_LATENCY-1, but it is never narrower than one bit.
   function automatic int cnt_width(input int latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request channels of the memory access unit: instruction fetch (i_*) and data load/store (d_*).
// The unit takes the slave side; the datapath/control unit takes the master side.
interface mem_access_unit_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ready;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ready;
   logic [DW-1:0] d_rdata;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_ready, i_rdata, d_ready, d_rdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_ready, i_rdata, d_ready, d_rdata
   );
endinterface

// File: rtl/mem_access_unit_arbiter.sv
// Combinational grant between the fetch and data channels.
// On a tie, D wins when DATA_PRIORITY is set; otherwise the channel not granted last time wins.
module mem_arbiter
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_PRIORITY = 1
) (
   input  logic i_req,
   input  logic d_req,
   input  src_e last_grant,
   output logic grant_valid,
   output src_e grant_src
);

   always_comb begin
      grant_valid = i_req | d_req;
      grant_src   = SRC_I;
      if (i_req && d_req) begin
         if (DATA_PRIORITY != 0) begin
            grant_src = SRC_D;
         end else if (last_grant == SRC_I) begin
            grant_src = SRC_D;
         end else begin
            grant_src = SRC_I;
         end
      end else if (d_req) begin
         grant_src = SRC_D;
      end
   end

endmodule

// File: rtl/mem_access_unit_counter.sv
// Access FSM (IDLE -> ACCESS -> DONE) and the latency counter that times the ACCESS phase.
// load marks the grant edge; capture marks the last ACCESS edge, where read data is sampled.
module access_counter
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   grant_valid,
   output state_e state,
   output logic   load,
   output logic   capture
);

   localparam int CNT_W = cnt_width(MEM_LATENCY);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d = ACCESS;
               count_d = CNT_INIT;
            end
         end
         ACCESS: begin
            if (count_q == '0) begin
               state_d = DONE;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      state   = state_q;
      load    = (state_q == IDLE) && grant_valid;
      capture = (state_q == ACCESS) && (count_q == '0);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Single-port memory access controller: arbitrates fetch and data requests onto one memory,
// holds strobes/address for MEM_LATENCY cycles and drives the shared data bus only during writes.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int WORD_SIZE     = 16,
   parameter int ADDR_WIDTH    = 16,
   parameter int MEM_LATENCY   = 2,
   parameter int DATA_PRIORITY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_access_unit_if.slave      cpu,
   output logic                  read_m,
   output logic                  write_m,
   output logic [ADDR_WIDTH-1:0] address,
   inout  wire  [WORD_SIZE-1:0]  data,
   output logic                  busy
);

   state_e                state;
   logic                  load, capture, grant_valid;
   src_e                  grant_src;

   src_e                  src_q, src_d;
   src_e                  last_grant_q, last_grant_d;
   logic [WORD_SIZE-1:0]  i_rdata_q, i_rdata_d;
   logic [WORD_SIZE-1:0]  d_rdata_q, d_rdata_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [WORD_SIZE-1:0]  wdata_q, wdata_d;

   mem_arbiter #(.DATA_PRIORITY(DATA_PRIORITY)) u_arb (
      .i_req       (cpu.i_req),
      .d_req       (cpu.d_req),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_src   (grant_src)
   );

   access_counter #(.MEM_LATENCY(MEM_LATENCY)) u_ctr (
      .clk         (clk),
      .reset       (reset),
      .grant_valid (grant_valid),
      .state       (state),
      .load        (load),
      .capture     (capture)
   );

   // Request fields are latched once at the grant edge; later input changes are ignored.
   always_comb begin
      src_d        = src_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      if (load) begin
         src_d        = grant_src;
         last_grant_d = grant_src;
         addr_d       = (grant_src == SRC_D) ? cpu.d_addr : cpu.i_addr;
         we_d         = (grant_src == SRC_D) && cpu.d_we;
         wdata_d      = cpu.d_wdata;
      end
      if (capture && !we_q) begin
         if (src_q == SRC_D) d_rdata_d = data;
         else                i_rdata_d = data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q        <= SRC_I;
         last_grant_q <= SRC_I;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         src_q        <= src_d;
         last_grant_q <= last_grant_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
   end

   // Everything memory-facing decodes from the registered state, never from the request inputs.
   assign read_m      = (state == ACCESS) && !we_q;
   assign write_m     = (state == ACCESS) && we_q;
   assign address     = (state == ACCESS) ? addr_q : '0;
   assign busy        = (state != IDLE);
   assign data        = write_m ? wdata_q : 'z;
   assign cpu.i_ready = (state == DONE) && (src_q == SRC_I);
   assign cpu.d_ready = (state == DONE) && (src_q == SRC_D);
   assign cpu.i_rdata = i_rdata_q;
   assign cpu.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: three instances (latency 2 with D priority, latency 2
// round-robin, latency 1) sharing clock and reset, each with a small memory model on its bus.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(16), .DW(16)) a_if ();
  mem_access_unit_if #(.AW(16), .DW(16)) b_if ();
  mem_access_unit_if #(.AW(16), .DW(16)) c_if ();

  logic        a_read_m, a_write_m, a_busy;
  logic        b_read_m, b_write_m, b_busy;
  logic        c_read_m, c_write_m, c_busy;
  logic [15:0] a_addr, b_addr, c_addr;
  wire  [15:0] a_data, b_data, c_data;
  logic [15:0] a_wr_addr, a_wr_data, b_wr_addr, b_wr_data, c_wr_addr, c_wr_data;

  mem_access_unit #(.WORD_SIZE(16), .ADDR_WIDTH(16), .MEM_LATENCY(2), .DATA_PRIORITY(1)) u_a (
    .clk(clk), .reset(reset), .cpu(a_if.slave), .read_m(a_read_m), .write_m(a_write_m),
    .address(a_addr), .data(a_data), .busy(a_busy));
  mem_access_unit #(.WORD_SIZE(16), .ADDR_WIDTH(16), .MEM_LATENCY(2), .DATA_PRIORITY(0)) u_b (
    .clk(clk), .reset(reset), .cpu(b_if.slave), .read_m(b_read_m), .write_m(b_write_m),
    .address(b_addr), .data(b_data), .busy(b_busy));
  mem_access_unit #(.WORD_SIZE(16), .ADDR_WIDTH(16), .MEM_LATENCY(1), .DATA_PRIORITY(1)) u_c (
    .clk(clk), .reset(reset), .cpu(c_if.slave), .read_m(c_read_m), .write_m(c_write_m),
    .address(c_addr), .data(c_data), .busy(c_busy));

  // Read-only contents seen by all three memories; writes are recorded separately.
  function automatic logic [15:0] rom(input logic [15:0] addr);
    case (addr)
      16'h0010: rom = 16'h6A05;
      16'h0030: rom = 16'h1234;
      16'h0040: rom = 16'h5678;
      16'h0050: rom = 16'hAAAA;
      16'h0060: rom = 16'hBBBB;
      16'h0070: rom = 16'hC0DE;
      default:  rom = addr ^ 16'hFFFF;
    endcase
  endfunction

  assign a_data = a_read_m ? rom(a_addr) : 'z;
  assign b_data = b_read_m ? rom(b_addr) : 'z;
  assign c_data = c_read_m ? rom(c_addr) : 'z;

  always @(posedge clk) begin
    if (a_write_m) begin a_wr_addr = a_addr; a_wr_data = a_data; end
    if (b_write_m) begin b_wr_addr = b_addr; b_wr_data = b_data; end
    if (c_write_m) begin c_wr_addr = c_addr; c_wr_data = c_data; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_if.i_req = 0; a_if.i_addr = 0; a_if.d_req = 0; a_if.d_we = 0; a_if.d_addr = 0; a_if.d_wdata = 0;
    b_if.i_req = 0; b_if.i_addr = 0; b_if.d_req = 0; b_if.d_we = 0; b_if.d_addr = 0; b_if.d_wdata = 0;
    c_if.i_req = 0; c_if.i_addr = 0; c_if.d_req = 0; c_if.d_we = 0; c_if.d_addr = 0; c_if.d_wdata = 0;
    repeat (2) tick();

    // reset state
    check("rst_busy",    a_busy, 0);
    check("rst_read_m",  a_read_m, 0);
    check("rst_write_m", a_write_m, 0);
    check("rst_address", a_addr, 0);
    check("rst_i_ready", a_if.i_ready, 0);
    check("rst_d_ready", a_if.d_ready, 0);
    check("rst_i_rdata", a_if.i_rdata, 0);
    check("rst_d_rdata", a_if.d_rdata, 0);
    reset = 1'b0;

    // fetch only, latency 2
    a_if.i_req = 1; a_if.i_addr = 16'h0010;
    tick();
    check("f1_read_m", a_read_m, 1);
    check("f1_addr",   a_addr, 16'h0010);
    check("f1_busy",   a_busy, 1);
    tick();
    check("f2_read_m", a_read_m, 1);
    check("f2_addr",   a_addr, 16'h0010);
    check("f2_i_ready", a_if.i_ready, 0);
    tick();
    check("f3_i_ready", a_if.i_ready, 1);
    check("f3_i_rdata", a_if.i_rdata, 16'h6A05);
    check("f3_read_m",  a_read_m, 0);
    tick();
    a_if.i_req = 0;
    check("f4_i_ready", a_if.i_ready, 0);
    check("f4_busy",    a_busy, 0);
    check("f4_i_rdata_hold", a_if.i_rdata, 16'h6A05);

    // data write; inputs change mid-access
    a_if.d_req = 1; a_if.d_we = 1; a_if.d_addr = 16'h0020; a_if.d_wdata = 16'hBEEF;
    tick();
    check("w1_write_m", a_write_m, 1);
    check("w1_read_m",  a_read_m, 0);
    check("w1_data",    a_data, 16'hBEEF);
    a_if.d_wdata = 16'h1111; a_if.d_addr = 16'h0099;
    tick();
    check("w2_write_m", a_write_m, 1);
    check("w2_addr",    a_addr, 16'h0020);
    check("w2_data",    a_data, 16'hBEEF);
    tick();
    check("w3_d_ready", a_if.d_ready, 1);
    check("w3_write_m", a_write_m, 0);
    check("w3_mem_addr", a_wr_addr, 16'h0020);
    check("w3_mem_data", a_wr_data, 16'hBEEF);
    tick();
    a_if.d_req = 0; a_if.d_we = 0;
    check("w4_d_ready", a_if.d_ready, 0);

    // tie with data priority: D first, I four cycles after d_ready
    a_if.i_req = 1; a_if.i_addr = 16'h0030;
    a_if.d_req = 1; a_if.d_addr = 16'h0040;
    tick();
    check("t1_addr", a_addr, 16'h0040);
    tick();
    tick();
    check("t3_d_ready", a_if.d_ready, 1);
    check("t3_d_rdata", a_if.d_rdata, 16'h5678);
    check("t3_i_ready", a_if.i_ready, 0);
    tick();
    a_if.d_req = 0;
    check("t4_busy", a_busy, 0);
    tick();
    check("t5_addr", a_addr, 16'h0030);
    tick();
    tick();
    check("t7_i_ready", a_if.i_ready, 1);
    check("t7_i_rdata", a_if.i_rdata, 16'h1234);
    tick();
    a_if.i_req = 0;

    // reset in the second ACCESS cycle of a read
    a_if.i_req = 1; a_if.i_addr = 16'h0010;
    tick();
    tick();
    check("r0_read_m", a_read_m, 1);
    reset = 1'b1;
    #1;
    check("r_read_m",  a_read_m, 0);
    check("r_busy",    a_busy, 0);
    check("r_i_ready", a_if.i_ready, 0);
    check("r_i_rdata", a_if.i_rdata, 0);
    check("r_addr",    a_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    check("r1_read_m", a_read_m, 1);
    check("r1_addr",   a_addr, 16'h0010);
    tick();
    tick();
    check("r3_i_ready", a_if.i_ready, 1);
    check("r3_i_rdata", a_if.i_rdata, 16'h6A05);
    tick();
    a_if.i_req = 0;

    // round-robin tie, both requests held: D,I,D,I
    b_if.i_req = 1; b_if.i_addr = 16'h0050;
    b_if.d_req = 1; b_if.d_we = 0; b_if.d_addr = 16'h0060;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("rr_d_ready", b_if.d_ready, (k == 3 || k == 11));
      check("rr_i_ready", b_if.i_ready, (k == 7 || k == 15));
      if (k % 4 == 1) check("rr_addr", b_addr, (k % 8 == 1) ? 16'h0060 : 16'h0050);
    end
    b_if.i_req = 0; b_if.d_req = 0;
    check("rr_d_rdata", b_if.d_rdata, 16'hBBBB);
    check("rr_i_rdata", b_if.i_rdata, 16'hAAAA);

    // latency 1: back-to-back fetches every 3 cycles
    c_if.i_req = 1; c_if.i_addr = 16'h0070;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("l1_i_ready", c_if.i_ready, (k % 3 == 2));
      check("l1_read_m",  c_read_m, (k % 3 == 1));
      check("l1_overlap", c_read_m & c_write_m, 0);
    end
    c_if.i_req = 0;
    check("l1_i_rdata", c_if.i_rdata, 16'hC0DE);
    tick();
    c_if.d_req = 1; c_if.d_we = 1; c_if.d_addr = 16'h0071; c_if.d_wdata = 16'h5A5A;
    tick();
    check("l1w_write_m", c_write_m, 1);
    check("l1w_read_m",  c_read_m, 0);
    tick();
    check("l1w_d_ready", c_if.d_ready, 1);
    check("l1w_mem_data", c_wr_data, 16'h5A5A);
    check("l1w_mem_addr", c_wr_addr, 16'h0071);
    tick();
    c_if.d_req = 0;
    check("l1w_busy", c_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
